multi_cycle_control: RTL
========================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter RESET_PC_WRITE, default 0, meaning the pc_write value driven while rst is high.
REQ-002 SHALL have port clk, input, 1 bit, the sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port opcode, input, 7 bits, instruction-register opcode field.
REQ-005 SHALL have port funct3, input, 3 bits, instruction-register funct3 field.
REQ-006 SHALL have port funct7b5, input, 1 bit, instruction bit 30.
REQ-007 SHALL have port zero, input, 1 bit, ALU zero flag.
REQ-008 SHALL have port mem_ready, input, 1 bit, memory access-complete handshake.
REQ-009 SHALL have outputs pc_write, adr_src, mem_write, ir_write and reg_write, 1 bit each, as the datapath enables and selects.
REQ-010 SHALL have outputs result_src, alu_src_a and alu_src_b, 2 bits each, as the datapath mux selects.
REQ-011 SHALL have output imm_select, 2 bits, the immediate-extender mode: 00 I, 01 S, 10 B, 11 reserved.
REQ-012 SHALL have output alu_control, 3 bits: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-013 SHALL have output illegal, 1 bit, sticky flag for an undecoded opcode.

Function
REQ-014 SHALL implement Moore states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH and HALT.
REQ-015 FETCH SHALL drive adr_src=0, alu_src_a=00, alu_src_b=10, alu add and result_src=10; while mem_ready=0 it SHALL hold with ir_write=pc_write=0; with mem_ready=1 it SHALL pulse ir_write=pc_write=1 for one cycle and go to DECODE.
REQ-016 DECODE SHALL drive alu_src_a=01, alu_src_b=01, alu add and imm_select=10 (branch-target precompute).
REQ-017 DECODE SHALL branch on opcode: 0000011 or 0100011 to MEMADR, 0110011 to EXECR, 0010011 to EXECI, 1100011 to BRANCH, and any other value to HALT.
REQ-018 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, alu add, imm_select=00 for loads or 01 for stores, then go to MEMREAD for loads or MEMWRITE for stores.
REQ-019 MEMREAD SHALL drive adr_src=1, result_src=00, and wait for mem_ready=1 before moving to MEMWB.
REQ-020 MEMWRITE SHALL drive adr_src=1, result_src=00, mem_write=1, and hold until mem_ready=1, then go to FETCH.
REQ-021 MEMWB SHALL drive result_src=01 and reg_write=1 for exactly one cycle, then go to FETCH.
REQ-022 EXECR SHALL drive alu_src_a=10 and alu_src_b=00; alu_control SHALL come from funct3: 000 gives sub if funct7b5=1, else add; 010 slt; 110 or; 111 and.
REQ-023 EXECI SHALL drive alu_src_b=01 and imm_select=00, with the same funct3 decode except that funct7b5 is ignored (000 is always add).
REQ-024 Both EXECR and EXECI SHALL go to ALUWB, which drives result_src=00 and reg_write=1 for one cycle, then goes to FETCH.
REQ-025 BRANCH SHALL drive alu_src_a=10, alu_src_b=00, alu sub and result_src=00, assert pc_write=zero in that same cycle, then go to FETCH.
REQ-026 Any funct3 not listed in REQ-022 SHALL produce alu_control=000.
REQ-027 Outputs not named for a state SHALL be 0 in that state.
REQ-028 HALT SHALL set illegal=1, drive all enables 0, and remain in HALT until reset.
REQ-029 Write-side enables (pc_write, ir_write, mem_write, reg_write) SHALL never assert while mem_ready gating is pending, except for mem_write in MEMWRITE.

Reset
REQ-030 While rst=1 at a clock edge, the state SHALL become FETCH and illegal SHALL clear to 0; reset SHALL take priority over all transitions, including mid-wait in MEMREAD or MEMWRITE.
REQ-031 While rst=1, pc_write SHALL equal RESET_PC_WRITE and every other enable SHALL be 0.

Structure
REQ-032 The state enum, opcode constants, imm_select and alu_control encodings SHALL live in the shared package cpu_pkg.
REQ-033 The funct3/funct7b5 decode SHALL be a sub-module named alu_decoder; the FSM remains in multi_cycle_control.

Verification
REQ-034 Bench SHALL apply R-type add with mem_ready=1 and check FETCH, DECODE, EXECR, ALUWB, FETCH with reg_write high only in cycle 4 and alu_control=000.
REQ-035 Bench SHALL apply funct3=000 with funct7b5=1 for opcode 0110011 (alu_control=001) and opcode 0010011 (alu_control=000).
REQ-036 Bench SHALL apply lw with mem_ready held low 3 cycles in MEMREAD and check that the state holds and reg_write stays 0, then reaches MEMWB one cycle after mem_ready rises.
REQ-037 Bench SHALL apply sw and check imm_select=01 in MEMADR and mem_write=1 until mem_ready, and beq with zero=1 then zero=0 and check pc_write of 1 and 0 in BRANCH.
REQ-038 Bench SHALL apply opcode 1111111 and check illegal=1 and HALT persisting 10 cycles, then rst=1 and check FETCH with illegal=0 on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the multi-cycle control unit
// FSM state codes, opcode constants, immediate modes and ALU operations.
package cpu_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_HALT     = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] IMM_I    = 2'b00;
    localparam logic [1:0] IMM_S    = 2'b01;
    localparam logic [1:0] IMM_B    = 2'b10;
    localparam logic [1:0] IMM_RSVD = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - funct3/funct7b5 to ALU operation decode
// use_funct7 is high only for register-register ops, where bit 30 selects sub.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       use_funct7,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            3'b000:  alu_control = (use_funct7 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control = ALU_SLT;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - Moore FSM sequencing a multi-cycle datapath
// Outputs depend on state only, except fetch/branch write strobes and reset overrides.
module multi_cycle_control
    import cpu_pkg::*;
#(
    parameter logic RESET_PC_WRITE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_select,
    output logic [2:0] alu_control,
    output logic       illegal
);

    state_t     state;
    state_t     next_state;
    logic [2:0] dec_alu;

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .use_funct7  (state == S_EXECR),
        .alu_control (dec_alu)
    );

    // illegal is raised on the edge that enters HALT, so it is visible in HALT itself
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_HALT) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    default:           next_state = S_HALT;
                endcase
            end
            S_MEMADR:   next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_HALT:     next_state = S_HALT;
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_select  = IMM_I;
        alu_control = ALU_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                imm_select = IMM_B;
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                imm_select = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = dec_alu;
            end
            S_EXECI: begin
                alu_src_b   = 2'b01;
                alu_control = dec_alu;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = zero;
            end
            default: ;
        endcase
        // Reset overrides the state decode so enables are quiet before the first edge
        if (rst) begin
            pc_write  = RESET_PC_WRITE;
            adr_src   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule
